// File: rtl/mem_lsu_adapter_pkg.sv
// Shared types and helpers for the load/store front-end.
// Byte-lane masks and alignment rules live here so every unit agrees.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Lane mask for an access; zero when the size exceeds the word.
    function automatic logic [7:0] be_mask(
        input size_e      size,
        input logic [2:0] offset,
        input int         data_bytes
    );
        logic [7:0] w_ones;
        unique case (size)
            SZ_B: w_ones = 8'h01;
            SZ_H: w_ones = 8'h03;
            SZ_W: w_ones = 8'h0F;
            SZ_D: w_ones = 8'hFF;
        endcase
        if ((32'd1 << size) > 32'(data_bytes)) begin
            return 8'h00;
        end
        return w_ones << offset;
    endfunction

    function automatic logic is_aligned(
        input size_e      size,
        input logic [2:0] addr_low
    );
        logic w_ok;
        unique case (size)
            SZ_B: w_ok = 1'b1;
            SZ_H: w_ok = ~addr_low[0];
            SZ_W: w_ok = (addr_low[1:0] == 2'b00);
            SZ_D: w_ok = (addr_low == 3'b000);
        endcase
        return w_ok;
    endfunction

endpackage

// File: rtl/mem_lsu_adapter_if.sv
// Request/response port of the load/store adapter plus its SRAM side.
// slave is the adapter view; master is the core and memory environment.
interface mem_lsu_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8),
    parameter int BADDR_W    = ADDR_WIDTH + OFF_W
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [BADDR_W-1:0]    req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_BYTES-1:0] mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_wen
    );

endinterface

// File: rtl/mem_lsu_adapter_align.sv
// Read-data lane extraction: shift down by the byte offset, keep the
// accessed bytes and sign- or zero-extend them to the full word.
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [OFF_W-1:0]      i_off,
    input  size_e                 i_size,
    input  logic                  i_unsigned,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_x;
    logic [DATA_WIDTH-1:0] w_keep;
    logic                  w_sign;

    always_comb begin
        w_x    = i_rdata >> {i_off, 3'b000};
        w_keep = '1;
        w_sign = w_x[DATA_WIDTH-1];
        unique case (i_size)
            SZ_B: begin
                w_keep = DATA_WIDTH'(8'hFF);
                w_sign = w_x[7];
            end
            SZ_H: begin
                w_keep = DATA_WIDTH'(16'hFFFF);
                w_sign = w_x[15];
            end
            SZ_W: begin
                w_keep = DATA_WIDTH'(32'hFFFF_FFFF);
                w_sign = w_x[31];
            end
            SZ_D: begin
                w_keep = '1;
                w_sign = w_x[DATA_WIDTH-1];
            end
        endcase
        o_data = (w_x & w_keep)
               | (~w_keep & {DATA_WIDTH{w_sign & ~i_unsigned}});
    end

endmodule

// File: rtl/mem_lsu_adapter.sv
// Load/store front-end for a synchronous single-port SRAM: one request
// in flight, fixed two-cycle turnaround, lane-shifted stores and loads.
module mem_lsu_adapter
    import mem_lsu_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int OFF_W      = $clog2(DATA_BYTES),
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BADDR_W    = ADDR_WIDTH + OFF_W
) (
    input logic clk,
    input logic rst_n,
    mem_lsu_adapter_if.slave bus
);

    state_e r_state;
    state_e w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [OFF_W-1:0]      r_off;
    size_e                 r_size;
    logic                  r_uns;
    logic                  r_we;
    logic                  r_bad;

    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_fits;
    logic                  w_legal;
    logic                  w_store;
    logic [OFF_W-1:0]      w_off;
    size_e                 w_size;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_off    = bus.req_addr[OFF_W-1:0];
    assign w_size   = size_e'(bus.req_size);
    assign w_fits   = (w_size != SZ_D) || (DATA_BYTES == 8);
    assign w_legal  = w_fits && is_aligned(w_size, 3'(w_off));
    assign w_accept = bus.req_valid && w_req_ready;
    // Gated on accept first so X on idle request fields stays off mem_wen.
    assign w_store  = w_accept && bus.req_we && w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_ready = rst_n;
                if (bus.req_valid) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_req_ready = rst_n;
                    w_state_nxt = bus.req_valid ? ACCESS : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_off  <= '0;
            r_size <= SZ_B;
            r_uns  <= 1'b0;
            r_we   <= 1'b0;
            r_bad  <= 1'b0;
        end else if (w_accept) begin
            r_addr <= bus.req_addr[BADDR_W-1:OFF_W];
            r_off  <= w_off;
            r_size <= w_size;
            r_uns  <= bus.req_unsigned;
            r_we   <= bus.req_we;
            r_bad  <= ~w_legal;
        end
    end

    mem_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_align (
        .i_rdata    (bus.mem_rdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ext)
    );

    // SRAM data is only valid in ACCESS, so the response is latched there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else if (r_state == ACCESS) begin
            r_resp_err   <= r_bad;
            r_resp_rdata <= (r_we || r_bad) ? '0 : w_ext;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    assign bus.mem_addr  = w_accept ? bus.req_addr[BADDR_W-1:OFF_W]
                                    : r_addr;
    assign bus.mem_wen   = w_store
                         ? DATA_BYTES'(be_mask(w_size, 3'(w_off), DATA_BYTES))
                         : '0;
    assign bus.mem_wdata = w_store ? (bus.req_wdata << {w_off, 3'b000})
                                   : '0;

endmodule
